// File: rtl/fetch_if_id.sv
// fetch_if_id: PC/fetch stage with IF/ID register, skid buffer and redirect discard path
module fetch_if_id #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INS  = 16'h0800,
  parameter logic [4:0]  HALT_OP  = 5'b00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_decode,
  input  logic        flush_fetch,
  input  logic [15:0] redirect_pc,
  input  logic [15:0] imem_rdata,
  input  logic        imem_done,
  input  logic        imem_stall,
  output logic        imem_en,
  output logic [15:0] imem_addr,
  output logic [15:0] if_id_ins,
  output logic [15:0] if_id_pc_inc,
  output logic        if_id_valid,
  output logic        halted,
  output logic        align_err
);
  localparam logic [2:0] FETCH    = 3'd0;
  localparam logic [2:0] WAIT     = 3'd1;
  localparam logic [2:0] BUFFERED = 3'd2;
  localparam logic [2:0] DISCARD  = 3'd3;
  localparam logic [2:0] HALT     = 3'd4;
  logic [2:0]  state;
  logic [15:0] pc, pc_next, skid_ins, skid_pc;
  logic        busy, outstanding;
  assign pc_next     = pc + 16'd2;
  assign imem_en     = state == FETCH;
  assign imem_addr   = pc;
  assign halted      = state == HALT;
  assign busy        = state == FETCH || state == WAIT;
  // a request completing in the flush cycle is already retired, so nothing is left to discard
  assign outstanding = !imem_done && (state == WAIT || (state == FETCH && imem_stall));
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      if_id_ins    <= NOP_INS;
      if_id_pc_inc <= RESET_PC;
      if_id_valid  <= 1'b0;
      align_err    <= 1'b0;
      skid_ins     <= NOP_INS;
      skid_pc      <= RESET_PC;
    end else if (flush_fetch) begin
      pc        <= redirect_pc;
      align_err <= align_err | redirect_pc[0];
      if (state == DISCARD) begin
        state <= imem_done ? FETCH : DISCARD;
      end else begin
        if_id_ins    <= NOP_INS;
        if_id_pc_inc <= redirect_pc;
        if_id_valid  <= 1'b0;
        state        <= outstanding ? DISCARD : FETCH;
      end
    end else if (busy && imem_done) begin
      pc <= pc_next;
      if (stall_decode) begin
        skid_ins <= imem_rdata;
        skid_pc  <= pc_next;
        state    <= BUFFERED;
      end else begin
        if_id_ins    <= imem_rdata;
        if_id_pc_inc <= pc_next;
        if_id_valid  <= 1'b1;
        state        <= imem_rdata[15:11] == HALT_OP ? HALT : FETCH;
      end
    end else if (state == FETCH && imem_stall) begin
      state <= WAIT;
    end else if (state == BUFFERED && !stall_decode) begin
      if_id_ins    <= skid_ins;
      if_id_pc_inc <= skid_pc;
      if_id_valid  <= 1'b1;
      state        <= skid_ins[15:11] == HALT_OP ? HALT : FETCH;
    end else if (state == DISCARD && imem_done) begin
      state <= FETCH;
    end
  end
endmodule

// File: tb/tb_fetch_if_id.sv
// tb_fetch_if_id: directed scoreboard bench for the fetch stage and IF/ID register
module tb_fetch_if_id;
  logic        clk = 0, rst = 1, stall_decode = 0, flush_fetch = 0, imem_done = 0, imem_stall = 0;
  logic [15:0] redirect_pc = 0, imem_rdata, imem_addr, if_id_ins, if_id_pc_inc;
  logic        imem_en, if_id_valid, halted, align_err;
  int tests = 0, fails = 0;
  typedef struct packed {logic [15:0] ins; logic [15:0] pc_inc; logic v;} ent_t;
  ent_t sb[$];
  fetch_if_id dut (
    .clk(clk), .rst(rst), .stall_decode(stall_decode), .flush_fetch(flush_fetch),
    .redirect_pc(redirect_pc), .imem_rdata(imem_rdata), .imem_done(imem_done),
    .imem_stall(imem_stall), .imem_en(imem_en), .imem_addr(imem_addr),
    .if_id_ins(if_id_ins), .if_id_pc_inc(if_id_pc_inc), .if_id_valid(if_id_valid),
    .halted(halted), .align_err(align_err)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] ins_at(input logic [15:0] a);
    return a == 16'h0046 ? 16'h0000 : (16'h8000 ^ a);
  endfunction
  assign imem_rdata = ins_at(imem_addr);
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic sd, input logic fl, input logic [15:0] rp, input logic dn, input logic ms);
    stall_decode = sd; flush_fetch = fl; redirect_pc = rp; imem_done = dn; imem_stall = ms;
    @(posedge clk); #1;
  endtask
  task automatic expect_ifid(input logic [15:0] ins, input logic [15:0] pc_inc, input logic v);
    sb.push_back('{ins: ins, pc_inc: pc_inc, v: v});
  endtask
  task automatic check_ifid(input string tag);
    ent_t e;
    if (sb.size() == 0) begin
      tests++; fails++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".ins"}, {16'h0, if_id_ins}, {16'h0, e.ins});
      chk({tag, ".pc_inc"}, {16'h0, if_id_pc_inc}, {16'h0, e.pc_inc});
      chk({tag, ".valid"}, {31'h0, if_id_valid}, {31'h0, e.v});
    end
  endtask
  task automatic fetch_ok(input string tag, input logic [15:0] a);
    expect_ifid(ins_at(a), a + 16'd2, 1'b1);
    cyc(0, 0, 0, 1, 0);
    check_ifid(tag);
  endtask
  initial begin
    expect_ifid(16'h0800, 16'h0000, 1'b0);
    cyc(0, 0, 0, 1, 0);
    check_ifid("reset");
    chk("reset.halted", {31'h0, halted}, 0);
    chk("reset.align", {31'h0, align_err}, 0);
    chk("reset.en", {31'h0, imem_en}, 1);
    chk("reset.addr", {16'h0, imem_addr}, 0);
    rst = 0;
    fetch_ok("t1.a", 16'h0000);
    fetch_ok("t1.b", 16'h0002);
    fetch_ok("t1.c", 16'h0004);
    for (int i = 0; i < 3; i++) begin
      expect_ifid(ins_at(16'h0004), 16'h0006, 1'b1);
      cyc(0, 0, 0, 0, i == 0);
      check_ifid("t2.hold");
      chk("t2.en", {31'h0, imem_en}, 0);
      chk("t2.addr", {16'h0, imem_addr}, 16'h0006);
    end
    fetch_ok("t2.done", 16'h0006);
    chk("t2.pc", {16'h0, imem_addr}, 16'h0008);
    expect_ifid(ins_at(16'h0006), 16'h0008, 1'b1);
    cyc(1, 0, 0, 1, 0);
    check_ifid("t3.skid");
    chk("t3.en", {31'h0, imem_en}, 0);
    chk("t3.pc", {16'h0, imem_addr}, 16'h000A);
    expect_ifid(ins_at(16'h0006), 16'h0008, 1'b1);
    cyc(1, 0, 0, 0, 0);
    check_ifid("t3.hold");
    expect_ifid(ins_at(16'h0008), 16'h000A, 1'b1);
    cyc(0, 0, 0, 0, 0);
    check_ifid("t3.release");
    chk("t3.en2", {31'h0, imem_en}, 1);
    fetch_ok("t3.next", 16'h000A);
    expect_ifid(ins_at(16'h000A), 16'h000C, 1'b1);
    cyc(0, 0, 0, 0, 1);
    check_ifid("t4.wait");
    expect_ifid(16'h0800, 16'h0040, 1'b0);
    cyc(0, 1, 16'h0040, 0, 0);
    check_ifid("t4.flush");
    chk("t4.en", {31'h0, imem_en}, 0);
    expect_ifid(16'h0800, 16'h0040, 1'b0);
    cyc(0, 0, 0, 1, 0);
    check_ifid("t4.drop");
    chk("t4.addr", {16'h0, imem_addr}, 16'h0040);
    chk("t4.en2", {31'h0, imem_en}, 1);
    fetch_ok("t5.f40", 16'h0040);
    fetch_ok("t5.f42", 16'h0042);
    fetch_ok("t5.f44", 16'h0044);
    fetch_ok("t5.halt", 16'h0046);
    chk("t5.halted", {31'h0, halted}, 1);
    chk("t5.en", {31'h0, imem_en}, 0);
    expect_ifid(16'h0000, 16'h0048, 1'b1);
    cyc(0, 0, 0, 1, 0);
    check_ifid("t5.frozen");
    chk("t5.addr", {16'h0, imem_addr}, 16'h0048);
    expect_ifid(16'h0800, 16'h0010, 1'b0);
    cyc(0, 1, 16'h0010, 0, 0);
    check_ifid("t5.flush");
    chk("t5.unhalt", {31'h0, halted}, 0);
    chk("t5.addr2", {16'h0, imem_addr}, 16'h0010);
    chk("t5.align", {31'h0, align_err}, 0);
    expect_ifid(16'h0800, 16'h0011, 1'b0);
    cyc(0, 1, 16'h0011, 1, 0);
    check_ifid("t6.flush");
    chk("t6.align", {31'h0, align_err}, 1);
    chk("t6.addr", {16'h0, imem_addr}, 16'h0011);
    fetch_ok("t6.odd", 16'h0011);
    chk("t6.sticky", {31'h0, align_err}, 1);
    expect_ifid(16'h0800, 16'hFFFE, 1'b0);
    cyc(0, 1, 16'hFFFE, 0, 0);
    check_ifid("wrap.flush");
    fetch_ok("wrap.fetch", 16'hFFFE);
    chk("wrap.addr", {16'h0, imem_addr}, 16'h0000);
    expect_ifid(16'h0800, 16'h0020, 1'b0);
    cyc(1, 1, 16'h0020, 1, 0);
    check_ifid("flush_over_stall");
    chk("fos.addr", {16'h0, imem_addr}, 16'h0020);
    cyc(0, 0, 0, 0, 1);
    chk("t6.wait", {31'h0, imem_en}, 0);
    rst = 1;
    expect_ifid(16'h0800, 16'h0000, 1'b0);
    cyc(0, 0, 0, 1, 0);
    check_ifid("t6.rst");
    chk("t6.rst.align", {31'h0, align_err}, 0);
    chk("t6.rst.en", {31'h0, imem_en}, 1);
    chk("t6.rst.addr", {16'h0, imem_addr}, 0);
    rst = 0;
    fetch_ok("t6.after", 16'h0000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
